// File: rtl/ext_dma_pkg.sv
// Shared definitions for the external-SRAM <-> local-scratchpad DMA engine.
// Holds the FSM state encoding and the default bus geometry.
package ext_dma_pkg;

  localparam int unsigned EXT_AW_DEF = 26;
  localparam int unsigned LOC_AW_DEF = 10;
  localparam int unsigned DW_DEF     = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REQ = 3'd1,
    LD_WR  = 3'd2,
    ST_RD  = 3'd3,
    ST_CAP = 3'd4,
    ST_REQ = 3'd5,
    DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/ext_sram_dma.sv
// Single-channel DMA moving word bursts between an external memory port
// and a local single-port scratchpad, one word per handshake.
module ext_sram_dma
  import ext_dma_pkg::*;
#(
  parameter int unsigned EXT_AW = EXT_AW_DEF,
  parameter int unsigned LOC_AW = LOC_AW_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [EXT_AW-1:0] cmd_ext_addr,
  input  logic [LOC_AW-1:0] cmd_loc_addr,
  input  logic [LOC_AW:0]   cmd_len,
  output logic              busy,
  output logic              done,
  output logic [EXT_AW-1:0] R0_addr,
  output logic              R0_valid,
  input  logic              R0_ready,
  input  logic [DW-1:0]     R0_data,
  output logic [EXT_AW-1:0] W0_addr,
  output logic [DW-1:0]     W0_data,
  output logic              W0_valid,
  input  logic              W0_ready,
  output logic [LOC_AW-1:0] loc_addr,
  output logic              loc_en,
  output logic              loc_wmode,
  output logic [DW-1:0]     loc_wdata,
  input  logic [DW-1:0]     loc_rdata
);

  localparam int unsigned CW = LOC_AW + 1;

  state_e            state_q, state_d;
  logic [EXT_AW-1:0] ext_q, ext_d;
  logic [LOC_AW-1:0] loc_q, loc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     data_q, data_d;

  logic cmd_ready_q, busy_q, done_q, r0_valid_q, w0_valid_q, loc_en_q, loc_wmode_q;

  // Next-state and datapath update; addresses/count advance once per completed beat
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    loc_d   = loc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ext_d = cmd_ext_addr;
          loc_d = cmd_loc_addr;
          cnt_d = cmd_len;
          if (cmd_len == '0)  state_d = DONE;
          else if (cmd_dir)   state_d = ST_RD;
          else                state_d = LD_REQ;
        end
      end
      LD_REQ: begin
        if (R0_ready) begin
          data_d  = R0_data;
          state_d = LD_WR;
        end
      end
      LD_WR: begin
        ext_d   = ext_q + EXT_AW'(1);
        loc_d   = loc_q + LOC_AW'(1);
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? DONE : LD_REQ;
      end
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        data_d  = loc_rdata;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (W0_ready) begin
          ext_d   = ext_q + EXT_AW'(1);
          loc_d   = loc_q + LOC_AW'(1);
          cnt_d   = cnt_q - CW'(1);
          state_d = (cnt_q == CW'(1)) ? DONE : ST_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they align with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ext_q       <= '0;
      loc_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r0_valid_q  <= 1'b0;
      w0_valid_q  <= 1'b0;
      loc_en_q    <= 1'b0;
      loc_wmode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      loc_q       <= loc_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      r0_valid_q  <= (state_d == LD_REQ);
      w0_valid_q  <= (state_d == ST_REQ);
      loc_en_q    <= (state_d == LD_WR) || (state_d == ST_RD);
      loc_wmode_q <= (state_d == LD_WR);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign R0_addr   = ext_q;
  assign R0_valid  = r0_valid_q;
  assign W0_addr   = ext_q;
  assign W0_data   = data_q;
  assign W0_valid  = w0_valid_q;
  assign loc_addr  = loc_q;
  assign loc_en    = loc_en_q;
  assign loc_wmode = loc_wmode_q;
  assign loc_wdata = data_q;

endmodule
